// File: rtl/me_mb_scheduler.sv
// me_mb_scheduler: frame-level sequencer for the motion-estimation engine.
// Walks every macroblock of a frame in raster order. For each MB it requests
// a fetch, starts the ME engine, waits for its result (with a watchdog), and
// hands {coords, SAD, MV} downstream over a valid/ready handshake.
module me_mb_scheduler #(
  parameter int MB_COLS     = 8,
  parameter int MB_ROWS     = 6,
  parameter int SAD_W       = 16,
  parameter int MV_W        = 6,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  output logic             busy,
  output logic             frame_done,
  output logic             fetch_req,
  input  logic             fetch_done,
  output logic [7:0]       mb_x,
  output logic [7:0]       mb_y,
  input  logic             me_ready,
  output logic             me_start,
  input  logic             me_valid,
  input  logic [SAD_W-1:0] me_min_sad,
  input  logic [MV_W-1:0]  me_mv_x,
  input  logic [MV_W-1:0]  me_mv_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_mb_x,
  output logic [7:0]       res_mb_y,
  output logic [SAD_W-1:0] res_sad,
  output logic [MV_W-1:0]  res_mv_x,
  output logic [MV_W-1:0]  res_mv_y,
  output logic [23:0]      sad_total,
  output logic             err_timeout
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_RDY, S_START, S_WAIT_ME, S_OUTPUT
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WD_W-1:0] wd;
  logic            wd_last;
  logic            last_mb;
  logic            accept;
  logic [24:0]     sad_sum;

  // Watchdog expires on the cycle it reads TIMEOUT_CYC-1; a valid result
  // arriving on that same cycle still takes priority.
  assign wd_last = (wd == WD_W'(TIMEOUT_CYC - 1));
  assign last_mb = (mb_x == 8'(MB_COLS - 1)) && (mb_y == 8'(MB_ROWS - 1));
  assign accept  = (state == S_OUTPUT) && res_ready;
  // One extra bit catches overflow of the running frame SAD.
  assign sad_sum = {1'b0, sad_total} + 25'(res_sad);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:     if (frame_start) state_next = S_FETCH;
      S_FETCH:    if (fetch_done)  state_next = S_WAIT_RDY;
      S_WAIT_RDY: if (me_ready)    state_next = S_START;
      S_START:                     state_next = S_WAIT_ME;
      S_WAIT_ME:  if (me_valid || wd_last) state_next = S_OUTPUT;
      S_OUTPUT:   if (res_ready)   state_next = last_mb ? S_IDLE : S_FETCH;
      default:                     state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    busy      = (state != S_IDLE);
    fetch_req = (state == S_FETCH);
    me_start  = (state == S_START);
    res_valid = (state == S_OUTPUT);
  end

  // Datapath: MB position, watchdog, result capture, frame accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mb_x        <= '0;
      mb_y        <= '0;
      wd          <= '0;
      res_mb_x    <= '0;
      res_mb_y    <= '0;
      res_sad     <= '0;
      res_mv_x    <= '0;
      res_mv_y    <= '0;
      sad_total   <= '0;
      err_timeout <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == S_IDLE && frame_start) begin
        mb_x        <= '0;
        mb_y        <= '0;
        sad_total   <= '0;
        err_timeout <= 1'b0;
      end
      if (state == S_START) wd <= '0;
      if (state == S_WAIT_ME) begin
        wd <= wd + 1'b1;
        if (me_valid) begin
          res_mb_x <= mb_x;
          res_mb_y <= mb_y;
          res_sad  <= me_min_sad;
          res_mv_x <= me_mv_x;
          res_mv_y <= me_mv_y;
        end else if (wd_last) begin
          res_mb_x    <= mb_x;
          res_mb_y    <= mb_y;
          res_sad     <= '1;
          res_mv_x    <= '0;
          res_mv_y    <= '0;
          err_timeout <= 1'b1;
        end
      end
      if (accept) begin
        sad_total <= sad_sum[24] ? 24'hFFFFFF : sad_sum[23:0];
        if (last_mb) begin
          frame_done <= 1'b1;
        end else if (mb_x == 8'(MB_COLS - 1)) begin
          mb_x <= '0;
          mb_y <= mb_y + 8'd1;
        end else begin
          mb_x <= mb_x + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_me_mb_scheduler.sv
// Bench for me_mb_scheduler: a 2x2 / TIMEOUT_CYC=16 instance for functional
// scenarios and a 20x15 instance for SAD saturation. Expected results are
// pushed when the ME model is started and popped on each result handshake.
module tb_me_mb_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // small instance
  logic        frame_start = 0, fetch_done = 1, me_ready = 1, me_valid = 0, res_ready = 1;
  logic [15:0] me_min_sad = '0;
  logic [5:0]  me_mv_x = '0, me_mv_y = '0;
  logic        busy, frame_done, fetch_req, me_start, res_valid, err_timeout;
  logic [7:0]  mb_x, mb_y, res_mb_x, res_mb_y;
  logic [15:0] res_sad;
  logic [5:0]  res_mv_x, res_mv_y;
  logic [23:0] sad_total;

  me_mb_scheduler #(.MB_COLS(2), .MB_ROWS(2), .SAD_W(16), .MV_W(6), .TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .fetch_req(fetch_req), .fetch_done(fetch_done), .mb_x(mb_x), .mb_y(mb_y),
    .me_ready(me_ready), .me_start(me_start), .me_valid(me_valid), .me_min_sad(me_min_sad),
    .me_mv_x(me_mv_x), .me_mv_y(me_mv_y), .res_valid(res_valid), .res_ready(res_ready),
    .res_mb_x(res_mb_x), .res_mb_y(res_mb_y), .res_sad(res_sad), .res_mv_x(res_mv_x),
    .res_mv_y(res_mv_y), .sad_total(sad_total), .err_timeout(err_timeout));

  // large instance for saturation
  logic        b_frame_start = 0, b_me_valid = 0, b_pend = 0;
  logic        b_busy, b_frame_done, b_fetch_req, b_me_start, b_res_valid, b_err_timeout;
  logic [7:0]  b_mb_x, b_mb_y, b_res_mb_x, b_res_mb_y;
  logic [15:0] b_res_sad;
  logic [5:0]  b_res_mv_x, b_res_mv_y;
  logic [23:0] b_sad_total;
  int          b_res_cnt = 0, b_fd_cnt = 0;

  me_mb_scheduler #(.MB_COLS(20), .MB_ROWS(15), .SAD_W(16), .MV_W(6), .TIMEOUT_CYC(16)) u_big (
    .clk(clk), .rst(rst), .frame_start(b_frame_start), .busy(b_busy), .frame_done(b_frame_done),
    .fetch_req(b_fetch_req), .fetch_done(1'b1), .mb_x(b_mb_x), .mb_y(b_mb_y),
    .me_ready(1'b1), .me_start(b_me_start), .me_valid(b_me_valid), .me_min_sad(16'hFFFF),
    .me_mv_x(6'd0), .me_mv_y(6'd0), .res_valid(b_res_valid), .res_ready(1'b1),
    .res_mb_x(b_res_mb_x), .res_mb_y(b_res_mb_y), .res_sad(b_res_sad), .res_mv_x(b_res_mv_x),
    .res_mv_y(b_res_mv_y), .sad_total(b_sad_total), .err_timeout(b_err_timeout));

  int n_vec = 0, n_err = 0;
  logic [43:0] sb[$];
  int          dly_tab[4];
  logic [15:0] sad_val;
  int          exp_idx, dly = 0, res_cnt = 0, fd_cnt = 0;
  longint      exp_total;

  // ME engine model: answers dly_tab[idx] cycles after me_start (0 = never)
  always @(negedge clk) begin
    logic [43:0] e;
    int          d;
    me_valid = 1'b0;
    if (rst) begin
      dly = 0;
    end else begin
      if (dly > 0) begin
        dly = dly - 1;
        if (dly == 0) me_valid = 1'b1;
      end
      if (me_start) begin
        d = dly_tab[exp_idx % 4];
        if (d == 0) begin
          e = {8'(exp_idx % 2), 8'(exp_idx / 2), 16'hFFFF, 6'd0, 6'd0};
          exp_total = exp_total + 64'hFFFF;
        end else begin
          me_min_sad = sad_val + 16'(exp_idx);
          me_mv_x    = 6'(exp_idx + 1);
          me_mv_y    = 6'(-(exp_idx + 1));
          e = {8'(exp_idx % 2), 8'(exp_idx / 2), me_min_sad, me_mv_x, me_mv_y};
          exp_total = exp_total + longint'(me_min_sad);
          dly = d;
        end
        if (exp_total > 64'hFFFFFF) exp_total = 64'hFFFFFF;
        sb.push_back(e);
        exp_idx = exp_idx + 1;
      end
    end
  end

  // Result monitor: every handshake is checked against the scoreboard head
  always @(negedge clk) begin
    logic [43:0] e, got;
    if (frame_done) fd_cnt = fd_cnt + 1;
    if (res_valid && res_ready && !rst) begin
      got = {res_mb_x, res_mb_y, res_sad, res_mv_x, res_mv_y};
      res_cnt = res_cnt + 1;
      n_vec = n_vec + 1;
      if (sb.size() == 0) begin
        $display("FAIL result_unexpected got=%h required=none", got);
        n_err = n_err + 1;
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          $display("FAIL result got=%h required=%h", got, e);
          n_err = n_err + 1;
        end else begin
          $display("result (%0d,%0d) sad=%h mv=(%h,%h) ok", res_mb_x, res_mb_y, res_sad, res_mv_x, res_mv_y);
        end
      end
    end
  end

  // Large-instance ME model: answers one cycle after start with SAD all ones
  always @(negedge clk) begin
    b_me_valid = 1'b0;
    if (b_pend) begin b_me_valid = 1'b1; b_pend = 1'b0; end
    if (b_me_start) b_pend = 1'b1;
    if (b_res_valid) b_res_cnt = b_res_cnt + 1;
    if (b_frame_done) b_fd_cnt = b_fd_cnt + 1;
  end

  task automatic start_frame(input logic [15:0] s, input int d0, d1, d2, d3);
    sad_val = s;
    dly_tab[0] = d0; dly_tab[1] = d1; dly_tab[2] = d2; dly_tab[3] = d3;
    exp_idx = 0;
    exp_total = 0;
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (frame_done) ok = 1'b1;
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset;
    logic [67:0] o;
    #1;
    o = {busy, frame_done, fetch_req, me_start, res_valid, err_timeout, mb_x, mb_y, res_sad, sad_total};
    n_vec++;
    if (o !== 68'd0) begin $display("FAIL reset_outputs got=%h required=0", o); n_err++; end
    else $display("reset outputs ok");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({busy, fetch_req, res_valid} !== 3'b000) begin
      $display("FAIL idle_after_reset got=%b required=000", {busy, fetch_req, res_valid}); n_err++;
    end
  endtask

  task automatic test_frame;
    bit ok; int r0, f0;
    r0 = res_cnt; f0 = fd_cnt;
    start_frame(16'd100, 5, 5, 5, 5);
    // results are checked on handshake; sad stays at 100 + idx for the model
    wait_done(200, ok);
    n_vec++;
    if (!ok) begin $display("FAIL frame_timeout got=no_done required=done"); n_err++; end
    n_vec++;
    if (res_cnt - r0 !== 4) begin $display("FAIL frame_results got=%0d required=4", res_cnt - r0); n_err++; end
    n_vec++;
    if (sad_total !== 24'(exp_total)) begin
      $display("FAIL frame_sad_total got=%0d required=%0d", sad_total, exp_total); n_err++;
    end
    n_vec++;
    if (fd_cnt - f0 !== 1 || busy !== 1'b0 || err_timeout !== 1'b0) begin
      $display("FAIL frame_end got=fd%0d/busy%b/err%b required=fd1/busy0/err0", fd_cnt - f0, busy, err_timeout);
      n_err++;
    end
    $display("frame 2x2 sad_total=%0d", sad_total);
  endtask

  task automatic test_back_pressure;
    bit ok; logic [43:0] snap, cur;
    res_ready = 1'b0;
    start_frame(16'd200, 2, 2, 2, 2);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin @(posedge clk); #1; if (res_valid) ok = 1'b1; end
    n_vec++;
    if (!ok) begin $display("FAIL stall_no_valid got=0 required=1"); n_err++; end
    snap = {res_mb_x, res_mb_y, res_sad, res_mv_x, res_mv_y};
    n_vec++;
    if (snap !== {8'd0, 8'd0, 16'd200, 6'd1, 6'h3F}) begin
      $display("FAIL stall_first got=%h required=%h", snap, {8'd0, 8'd0, 16'd200, 6'd1, 6'h3F}); n_err++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cur = {res_mb_x, res_mb_y, res_sad, res_mv_x, res_mv_y};
      n_vec++;
      if (cur !== snap || res_valid !== 1'b1 || fetch_req !== 1'b0) begin
        $display("FAIL stall_hold cyc%0d got=%h/v%b/f%b required=%h/v1/f0", i, cur, res_valid, fetch_req, snap);
        n_err++;
      end
    end
    $display("stall held 10 cycles");
    res_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (res_valid !== 1'b0 || fetch_req !== 1'b1 || mb_x !== 8'd1) begin
      $display("FAIL stall_release got=v%b/f%b/x%0d required=v0/f1/x1", res_valid, fetch_req, mb_x); n_err++;
    end
    wait_done(200, ok);
    n_vec++;
    if (!ok || sb.size() != 0) begin $display("FAIL stall_finish got=%0d/%0d required=1/0", ok, sb.size()); n_err++; end
  endtask

  task automatic test_timeout;
    bit ok;
    // MB0 answers exactly on the watchdog's final cycle, MB1 never answers
    start_frame(16'd50, 16, 0, 3, 3);
    wait_done(400, ok);
    n_vec++;
    if (!ok) begin $display("FAIL timeout_no_done got=0 required=1"); n_err++; end
    n_vec++;
    if (err_timeout !== 1'b1) begin $display("FAIL timeout_err got=%b required=1", err_timeout); n_err++; end
    n_vec++;
    if (sad_total !== 24'(exp_total)) begin
      $display("FAIL timeout_sad_total got=%h required=%h", sad_total, 24'(exp_total)); n_err++;
    end
    $display("timeout frame err=%b sad_total=%h", err_timeout, sad_total);
  endtask

  task automatic test_midframe_start;
    bit ok; int f0;
    f0 = fd_cnt;
    start_frame(16'd10, 6, 6, 6, 6);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin @(posedge clk); #1; if (me_start && mb_x == 8'd1) ok = 1'b1; end
    frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    n_vec++;
    if (!ok || mb_x !== 8'd1 || mb_y !== 8'd0 || busy !== 1'b1) begin
      $display("FAIL midstart_coords got=(%0d,%0d)/b%b required=(1,0)/b1", mb_x, mb_y, busy); n_err++;
    end
    wait_done(200, ok);
    n_vec++;
    if (!ok || fd_cnt - f0 !== 1 || sb.size() != 0) begin
      $display("FAIL midstart_finish got=%0d/%0d/%0d required=1/1/0", ok, fd_cnt - f0, sb.size()); n_err++;
    end
    $display("mid-frame frame_start ignored");
  endtask

  task automatic test_async_reset;
    bit ok; int f0; logic [67:0] o;
    start_frame(16'd30, 9, 9, 9, 9);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin @(posedge clk); #1; if (me_start) ok = 1'b1; end
    @(posedge clk); #3;
    f0 = fd_cnt;
    rst = 1'b1;
    #1;
    o = {busy, frame_done, fetch_req, me_start, res_valid, err_timeout, mb_x, mb_y, res_sad, sad_total};
    n_vec++;
    if (!ok || o !== 68'd0) begin $display("FAIL async_reset got=%h required=0", o); n_err++; end
    repeat (2) @(negedge clk);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (fd_cnt !== f0 || busy !== 1'b0) begin
      $display("FAIL async_reset_quiet got=fd%0d/b%b required=fd%0d/b0", fd_cnt, busy, f0); n_err++;
    end
    $display("async reset in WAIT_ME ok");
    test_frame();
  endtask

  task automatic test_saturation;
    bit ok;
    @(posedge clk); #1 b_frame_start = 1'b1;
    @(posedge clk); #1 b_frame_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin @(posedge clk); #1; if (b_frame_done) ok = 1'b1; end
    @(negedge clk); #1;
    n_vec++;
    if (!ok || b_res_cnt !== 300 || b_fd_cnt !== 1) begin
      $display("FAIL sat_frame got=%0d/%0d/%0d required=1/300/1", ok, b_res_cnt, b_fd_cnt); n_err++;
    end
    n_vec++;
    if (b_sad_total !== 24'hFFFFFF || b_err_timeout !== 1'b0) begin
      $display("FAIL sat_total got=%h/%b required=ffffff/0", b_sad_total, b_err_timeout); n_err++;
    end
    $display("20x15 frame sad_total=%h", b_sad_total);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dly_tab[i] = 1;
    sad_val = '0;
    exp_idx = 0;
    exp_total = 0;
    test_reset();
    test_frame();
    test_back_pressure();
    test_timeout();
    test_midframe_start();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
